// File: rtl/utf8_stream_arbiter_if.sv
// Byte-stream bundle between the two UTF-8 sources, the arbiter and the decoder.
// slave = arbiter side, master = sources/decoder side.
interface utf8_stream_arbiter_if;
  logic [7:0] a_byte;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_byte;
  logic       b_valid;
  logic       b_ready;
  logic       hold;
  logic [7:0] dec_byte;
  logic       dec_ie;
  logic       dec_src;
  logic       lock;
  logic       timeout_pulse;

  modport slave (
    input  a_byte, a_valid, b_byte, b_valid, hold,
    output a_ready, b_ready, dec_byte, dec_ie, dec_src, lock, timeout_pulse
  );

  modport master (
    output a_byte, a_valid, b_byte, b_valid, hold,
    input  a_ready, b_ready, dec_byte, dec_ie, dec_src, lock, timeout_pulse
  );
endinterface

// File: rtl/utf8_stream_arbiter.sv
// Two-source UTF-8 byte arbiter: keeps multi-byte sequences atomic, round-robins between them.
// Optional stall-timeout lock revocation is enabled by defining UTF8_ARB_TIMEOUT_EN.
module utf8_stream_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  utf8_stream_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] rem_reg, rem_next;
  logic       rr_reg, rr_next;          // 0 = A preferred next, 1 = B
  logic       a_ready_int, b_ready_int;
  logic       acc_a, acc_b, acc;
  logic       acc_src;
  logic [7:0] acc_byte;
  logic [2:0] acc_len;
  logic [2:0] acc_len_m1;
  logic       acc_is_cont;
  logic       revoke;

  logic [7:0] dec_byte_reg;
  logic       dec_ie_reg;
  logic       dec_src_reg;

  // Sequence length implied by a lead byte; malformed leads count as single bytes.
  function automatic logic [2:0] seq_len(input logic [7:0] b);
    logic [2:0] n;
    n = 3'd1;
    if (!b[7])
      n = 3'd1;
    else if (b[7:5] == 3'b110)
      n = 3'd2;
    else if (b[7:4] == 4'b1110)
      n = 3'd3;
    else if ((b[7:3] == 5'b11110) && (b[2:0] <= 3'd4))
      n = 3'd4;
    return n;
  endfunction

  assign acc_a       = a_ready_int & bus.a_valid;
  assign acc_b       = b_ready_int & bus.b_valid;
  assign acc         = acc_a | acc_b;
  assign acc_src     = acc_b;
  assign acc_byte    = acc_b ? bus.b_byte : bus.a_byte;
  assign acc_len     = seq_len(acc_byte);
  assign acc_len_m1  = acc_len - 3'd1;
  assign acc_is_cont = (acc_byte[7:6] == 2'b10);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      rem_reg   <= 2'd0;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      rr_reg    <= rr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    rr_next    = rr_reg;
    if (acc) begin
      rr_next = ~acc_src;
      if ((state_reg != ST_IDLE) && acc_is_cont) begin
        rem_next = rem_reg - 2'd1;
        if (rem_reg == 2'd1)
          state_next = ST_IDLE;
      end else if (acc_len_m1 == 3'd0) begin
        state_next = ST_IDLE;
        rem_next   = 2'd0;
      end else begin
        state_next = acc_src ? ST_LOCK_B : ST_LOCK_A;
        rem_next   = acc_len_m1[1:0];
      end
    end else if (revoke) begin
      state_next = ST_IDLE;
      rem_next   = 2'd0;
      rr_next    = (state_reg == ST_LOCK_A);
    end
  end

  // Output logic: grant selection
  always_comb begin
    a_ready_int = 1'b0;
    b_ready_int = 1'b0;
    if (!reset && !bus.hold) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.a_valid && (!bus.b_valid || !rr_reg))
            a_ready_int = 1'b1;
          else if (bus.b_valid)
            b_ready_int = 1'b1;
        end
        ST_LOCK_A: a_ready_int = 1'b1;
        ST_LOCK_B: b_ready_int = 1'b1;
        default: begin
          a_ready_int = 1'b0;
          b_ready_int = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_byte_reg <= 8'h00;
      dec_ie_reg   <= 1'b0;
      dec_src_reg  <= 1'b0;
    end else begin
      dec_ie_reg <= acc;
      if (acc) begin
        dec_byte_reg <= acc_byte;
        dec_src_reg  <= acc_src;
      end
    end
  end

`ifdef UTF8_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_reg, cnt_next;
  logic        timeout_pulse_reg;

  // An accept in the limit cycle takes precedence over revocation.
  assign revoke = (state_reg != ST_IDLE) && !acc && (cnt_reg == TIMEOUT_LIMIT);

  always_comb begin
    cnt_next = cnt_reg;
    if ((state_reg == ST_IDLE) || acc || revoke)
      cnt_next = 16'd0;
    else if (!bus.hold)
      cnt_next = cnt_reg + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg           <= 16'd0;
      timeout_pulse_reg <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      timeout_pulse_reg <= revoke;
    end
  end

  assign bus.timeout_pulse = timeout_pulse_reg;
`else
  assign revoke            = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  assign bus.a_ready  = a_ready_int;
  assign bus.b_ready  = b_ready_int;
  assign bus.dec_byte = dec_byte_reg;
  assign bus.dec_ie   = dec_ie_reg;
  assign bus.dec_src  = dec_src_reg;
  assign bus.lock     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_utf8_stream_arbiter.sv
// Directed bench for utf8_stream_arbiter: expected decoder bytes go into a scoreboard
// queue, a negedge monitor pops and compares them; control outputs are checked inline.
module tb_utf8_stream_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   to_seen = 0;
  logic [8:0] exp_q [$];

  utf8_stream_arbiter_if bus();

  utf8_stream_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [7:0] ab, input logic bv, input logic [7:0] bb);
    bus.a_valid = av;
    bus.a_byte  = ab;
    bus.b_valid = bv;
    bus.b_byte  = bb;
  endtask

  task automatic expect_dec(input logic src, input logic [7:0] b);
    exp_q.push_back({src, b});
  endtask

  // Scoreboard monitor
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (bus.timeout_pulse) to_seen++;
      if (bus.dec_ie) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dec_unexpected actual=src%0d/%02h required=none", bus.dec_src, bus.dec_byte);
        end else begin
          e = exp_q.pop_front();
          if ({bus.dec_src, bus.dec_byte} !== e) begin
            errors++;
            $display("FAIL dec_byte actual=src%0d/%02h required=src%0d/%02h",
                     bus.dec_src, bus.dec_byte, e[8], e[7:0]);
          end else
            $display("dec src%0d byte %02h ok", bus.dec_src, bus.dec_byte);
        end
      end
    end
  end

  initial begin
    bus.hold = 1'b0;
    drive(1'b1, 8'h41, 1'b0, 8'h00);
    // Reset: no ready while reset high
    repeat (3) nxt();
    @(negedge clk);
    chk("ready_in_reset", bus.a_ready, 0);
    nxt();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("rst_dec_byte", bus.dec_byte, 8'h00);
    chk("rst_dec_ie", bus.dec_ie, 0);
    chk("rst_dec_src", bus.dec_src, 0);
    chk("rst_lock", bus.lock, 0);
    chk("rst_timeout", bus.timeout_pulse, 0);

    // Single ASCII byte from A
    nxt();
    drive(1'b1, 8'h41, 1'b0, 8'h00);
    expect_dec(1'b0, 8'h41);
    @(negedge clk);
    chk("t1_a_ready", bus.a_ready, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("t1_lock", bus.lock, 0);

    // Lone B byte so that A is preferred next
    nxt();
    drive(1'b0, 8'h00, 1'b1, 8'h62);
    expect_dec(1'b1, 8'h62);
    nxt();

    // 3-byte sequence from A with gaps, B waiting
    drive(1'b1, 8'hE2, 1'b1, 8'h42);
    expect_dec(1'b0, 8'hE2);
    @(negedge clk);
    chk("t2_a_ready_lead", bus.a_ready, 1);
    chk("t2_b_ready_lead", bus.b_ready, 0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      drive(1'b0, 8'h00, 1'b1, 8'h42);
      @(negedge clk);
      chk("t2_b_blocked1", bus.b_ready, 0);
      chk("t2_lock1", bus.lock, 1);
    end
    nxt();
    drive(1'b1, 8'h82, 1'b1, 8'h42);
    expect_dec(1'b0, 8'h82);
    @(negedge clk);
    chk("t2_b_blocked_cont", bus.b_ready, 0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      drive(1'b0, 8'h00, 1'b1, 8'h42);
      @(negedge clk);
      chk("t2_b_blocked2", bus.b_ready, 0);
    end
    nxt();
    drive(1'b1, 8'hAC, 1'b1, 8'h42);
    expect_dec(1'b0, 8'hAC);
    @(negedge clk);
    chk("t2_a_ready_last", bus.a_ready, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b1, 8'h42);
    expect_dec(1'b1, 8'h42);
    @(negedge clk);
    chk("t2_b_ready_after", bus.b_ready, 1);
    chk("t2_lock_after", bus.lock, 0);

    // Both valid continuously: strict alternation starting with A
    for (int i = 0; i < 6; i++) begin
      nxt();
      drive(1'b1, 8'h61, 1'b1, 8'h62);
      if (i % 2 == 0) expect_dec(1'b0, 8'h61);
      else            expect_dec(1'b1, 8'h62);
      @(negedge clk);
      chk("t3_a_ready", bus.a_ready, (i % 2 == 0) ? 1 : 0);
      chk("t3_b_ready", bus.b_ready, (i % 2 == 1) ? 1 : 0);
    end

    // Lead byte E2 followed by ASCII: reclassified, lock released
    nxt();
    drive(1'b1, 8'hE2, 1'b1, 8'h42);
    expect_dec(1'b0, 8'hE2);
    nxt();
    drive(1'b1, 8'h41, 1'b1, 8'h42);
    expect_dec(1'b0, 8'h41);
    @(negedge clk);
    chk("t5_lock_mid", bus.lock, 1);
    chk("t5_b_blocked", bus.b_ready, 0);
    nxt();
    drive(1'b0, 8'h00, 1'b1, 8'h42);
    expect_dec(1'b1, 8'h42);
    @(negedge clk);
    chk("t5_lock_drop", bus.lock, 0);
    chk("t5_b_ready", bus.b_ready, 1);

    // 4-byte sequence with a 20-cycle hold in the middle
    nxt();
    drive(1'b1, 8'hF0, 1'b0, 8'h00);
    expect_dec(1'b0, 8'hF0);
    nxt();
    drive(1'b1, 8'h9F, 1'b0, 8'h00);
    expect_dec(1'b0, 8'h9F);
    nxt();
    bus.hold = 1'b1;
    drive(1'b1, 8'h98, 1'b1, 8'h42);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_hold_a_ready", bus.a_ready, 0);
      chk("t6_hold_lock", bus.lock, 1);
      nxt();
    end
    bus.hold = 1'b0;
    drive(1'b1, 8'h98, 1'b0, 8'h00);
    expect_dec(1'b0, 8'h98);
    @(negedge clk);
    chk("t6_timeout_none", to_seen, 0);
    nxt();
    drive(1'b1, 8'h80, 1'b0, 8'h00);
    expect_dec(1'b0, 8'h80);
    @(negedge clk);
    chk("t6_lock_last", bus.lock, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("t6_lock_done", bus.lock, 0);

    // Stalled 2-byte sequence from A with B waiting
    nxt();
    drive(1'b1, 8'hC3, 1'b0, 8'h00);
    expect_dec(1'b0, 8'hC3);
    nxt();
    drive(1'b0, 8'h00, 1'b1, 8'h42);
`ifdef UTF8_ARB_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t4_b_blocked", bus.b_ready, 0);
      chk("t4_no_pulse_yet", bus.timeout_pulse, 0);
      nxt();
    end
    expect_dec(1'b1, 8'h42);
    @(negedge clk);
    chk("t4_timeout_pulse", bus.timeout_pulse, 1);
    chk("t4_b_ready", bus.b_ready, 1);
    chk("t4_lock_revoked", bus.lock, 0);
    nxt();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("t4_pulse_once", to_seen, 1);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_b_blocked", bus.b_ready, 0);
      chk("t4_no_pulse", bus.timeout_pulse, 0);
      nxt();
    end
    drive(1'b1, 8'hA9, 1'b1, 8'h42);
    expect_dec(1'b0, 8'hA9);
    @(negedge clk);
    chk("t4_a_ready_cont", bus.a_ready, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b1, 8'h42);
    expect_dec(1'b1, 8'h42);
    @(negedge clk);
    chk("t4_b_ready", bus.b_ready, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
`endif

    // Reset in the middle of a sequence, then both valid: A first
    nxt();
    drive(1'b1, 8'hE2, 1'b0, 8'h00);
    expect_dec(1'b0, 8'hE2);
    nxt();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    nxt();
    nxt();
    reset = 1'b0;
    drive(1'b1, 8'h41, 1'b1, 8'h42);
    expect_dec(1'b0, 8'h41);
    @(negedge clk);
    chk("t7_lock_after_reset", bus.lock, 0);
    chk("t7_a_wins", bus.a_ready, 1);
    nxt();
    expect_dec(1'b1, 8'h42);
    @(negedge clk);
    chk("t7_b_next", bus.b_ready, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b0, 8'h00);

    repeat (4) nxt();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
